// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_latch_hs inter-stage register:
// FSM state encoding, occupancy values and per-stage default widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_e;

  localparam logic [1:0] OCC_ZERO = 2'd0;
  localparam logic [1:0] OCC_ONE  = 2'd1;
  localparam logic [1:0] OCC_TWO  = 2'd2;

  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned IF_ID_CTRL_W  = 1;
  localparam int unsigned ID_EX_DATA_W  = 138;
  localparam int unsigned ID_EX_CTRL_W  = 10;
  localparam int unsigned EX_MEM_DATA_W = 69;
  localparam int unsigned EX_MEM_CTRL_W = 10;
  localparam int unsigned MEM_WB_DATA_W = 69;
  localparam int unsigned MEM_WB_CTRL_W = 3;

  typedef enum logic [1:0] {
    STG_IF_ID,
    STG_ID_EX,
    STG_EX_MEM,
    STG_MEM_WB
  } stage_e;

  function automatic int unsigned stage_data_w(stage_e s);
    case (s)
      STG_IF_ID:  return IF_ID_DATA_W;
      STG_ID_EX:  return ID_EX_DATA_W;
      STG_EX_MEM: return EX_MEM_DATA_W;
      default:    return MEM_WB_DATA_W;
    endcase
  endfunction

  function automatic int unsigned stage_ctrl_w(stage_e s);
    case (s)
      STG_IF_ID:  return IF_ID_CTRL_W;
      STG_ID_EX:  return ID_EX_CTRL_W;
      STG_EX_MEM: return EX_MEM_CTRL_W;
      default:    return MEM_WB_CTRL_W;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One beat of storage: {valid, data, ctrl} with load enable, two-way load
// source select and a synchronous valid clear that leaves the payload intact.
module pipe_slot #(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CTRL_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              ld_en,
  input  logic              ld_sel,
  input  logic [DATA_W-1:0] a_data,
  input  logic [CTRL_W-1:0] a_ctrl,
  input  logic [DATA_W-1:0] b_data,
  input  logic [CTRL_W-1:0] b_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Clear wins over load so a flush also discards a same-cycle load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (ld_en) begin
      valid_d = 1'b1;
      data_d  = ld_sel ? b_data : a_data;
      ctrl_d  = ld_sel ? b_ctrl : a_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_latch_hs.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble and control outputs gated to zero when no beat is held.
module pipe_latch_hs
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = EX_MEM_DATA_W,
  parameter int unsigned CTRL_W = EX_MEM_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   in_fire, out_fire;
  logic   main_ld, main_sel, main_clr;
  logic   skid_ld, skid_clr;

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  always_comb begin
    in_fire  = in_valid & in_ready_q;
    out_fire = main_valid & out_ready;
    state_d  = state_q;
    main_ld  = 1'b0;
    main_sel = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_ld = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            skid_ld = 1'b1;
            state_d = FULL;
          end else if (out_fire) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_ld  = 1'b1;
            main_sel = 1'b1;
            skid_clr = 1'b1;
            state_d  = ONE;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
    // Registered ready: computed from the next state so it equals !skid_valid.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .reset  (reset),
    .clr    (main_clr),
    .ld_en  (main_ld),
    .ld_sel (main_sel),
    .a_data (in_data),
    .a_ctrl (in_ctrl),
    .b_data (skid_data),
    .b_ctrl (skid_ctrl),
    .valid  (main_valid),
    .data   (main_data),
    .ctrl   (main_ctrl)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .clr    (skid_clr),
    .ld_en  (skid_ld),
    .ld_sel (1'b0),
    .a_data (in_data),
    .a_ctrl (in_ctrl),
    .b_data (in_data),
    .b_ctrl (in_ctrl),
    .valid  (skid_valid),
    .data   (skid_data),
    .ctrl   (skid_ctrl)
  );

  always_comb begin
    case (state_q)
      ONE:     occupancy = OCC_ONE;
      FULL:    occupancy = OCC_TWO;
      default: occupancy = OCC_ZERO;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_latch_hs.sv
// Bench for pipe_latch_hs: directed vectors plus random traffic, with a
// scoreboard queue of accepted beats checked on every mid-cycle sample.
module tb_pipe_latch_hs;

  localparam int unsigned DW = 69;
  localparam int unsigned CW = 10;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;

  int total = 0;
  int bad   = 0;

  beat_t         exp_q[$];
  logic [DW-1:0] last_main;
  bit            armed = 1'b0;
  int            occ_m;
  bit            mdl_rdy;

  pipe_latch_hs #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: sampled mid-cycle, then advanced to the state after the next edge.
  always @(negedge clk) begin
    if (!armed) begin
      if (reset) begin
        armed = 1'b1;
        exp_q.delete();
        last_main = '0;
      end
    end else begin
      occ_m = exp_q.size();
      chk("sb_in_ready", in_ready, occ_m < 2);
      chk("sb_out_valid", out_valid, occ_m > 0);
      chk("sb_occupancy", occupancy, occ_m);
      if (occ_m > 0) begin
        chk("sb_out_data", out_data, exp_q[0].d);
        chk("sb_out_ctrl", out_ctrl, exp_q[0].c);
      end else begin
        chk("sb_hold_data", out_data, last_main);
        chk("sb_bubble_ctrl", out_ctrl, '0);
      end
      if (reset) begin
        exp_q.delete();
        last_main = '0;
      end else if (flush) begin
        exp_q.delete();
      end else begin
        mdl_rdy = (occ_m < 2);
        if (occ_m > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && mdl_rdy) exp_q.push_back({in_data, in_ctrl});
        if (exp_q.size() > 0) last_main = exp_q[0].d;
      end
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the consuming edge.
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl, input logic rst);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [95:0] r;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;

    repeat (2) drive(0, '0, '0, 0, 0, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_data", out_data, 0);

    for (int k = 1; k <= 8; k++) begin
      drive(1, DW'(k), 10'h3FF, 1, 0, 0);
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, k);
      chk("stream_ctrl", out_ctrl, 10'h3FF);
      chk("stream_occ", occupancy, 1);
    end
    drive(0, '0, '0, 1, 0, 0);
    chk("stream_drain", occupancy, 0);

    drive(1, 'hA, 10'h001, 1, 0, 0);
    chk("stall_a", out_data, 'hA);
    drive(1, 'hB, 10'h002, 0, 0, 0);
    chk("stall_occ2", occupancy, 2);
    chk("stall_rdy0", in_ready, 0);
    drive(1, 'hC, 10'h003, 0, 0, 0);
    chk("stall_hold_a", out_data, 'hA);
    chk("stall_occ_hold", occupancy, 2);
    drive(1, 'hC, 10'h003, 1, 0, 0);
    chk("stall_b", out_data, 'hB);
    chk("stall_recover", in_ready, 1);
    drive(1, 'hC, 10'h003, 1, 0, 0);
    chk("stall_c", out_data, 'hC);
    chk("stall_c_occ", occupancy, 1);
    drive(0, '0, '0, 1, 0, 0);
    chk("stall_empty", out_valid, 0);

    drive(1, 'h11, 10'h011, 0, 0, 0);
    drive(1, 'h12, 10'h012, 0, 0, 0);
    chk("flfull_occ2", occupancy, 2);
    drive(1, 'hD, 10'h0DD, 1, 1, 0);
    chk("flfull_valid", out_valid, 0);
    chk("flfull_ctrl", out_ctrl, 0);
    chk("flfull_occ", occupancy, 0);
    chk("flfull_rdy", in_ready, 1);
    chk("flfull_data_kept", out_data, 'h11);
    drive(0, '0, '0, 1, 0, 0);
    chk("flfull_no_d", out_valid, 0);

    drive(1, 'h21, 10'h021, 0, 0, 0);
    drive(1, 'hD, 10'h0DD, 0, 1, 0);
    chk("flone_valid", out_valid, 0);
    chk("flone_occ", occupancy, 0);
    drive(0, '0, '0, 1, 0, 0);
    chk("flone_no_d", out_valid, 0);

    drive(1, 'h55, 10'h2A3, 1, 0, 0);
    chk("bub_ctrl_live", out_ctrl, 10'h2A3);
    drive(0, '0, '0, 1, 0, 0);
    chk("bub_valid", out_valid, 0);
    chk("bub_ctrl", out_ctrl, 0);
    chk("bub_data", out_data, 'h55);

    drive(1, 'h31, 10'h031, 0, 0, 0);
    drive(1, 'h32, 10'h032, 0, 0, 0);
    drive(1, 'h33, 10'h033, 1, 1, 1);
    chk("rstmid_occ", occupancy, 0);
    chk("rstmid_data", out_data, 0);
    chk("rstmid_rdy", in_ready, 1);

    for (int n = 0; n < 10000; n++) begin
      r = {$urandom, $urandom, $urandom};
      drive($urandom_range(0, 9) < 6, r[DW-1:0], CW'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
            $urandom_range(0, 499) == 0);
    end
    repeat (4) drive(0, '0, '0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
